cpu_debug_display: RTL and testbench
====================================

CPU_DEBUG_DISPLAY -- requirements
Module: cpu_debug_display

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, setting the number of clk cycles each digit stays selected (legal range 2..2^20).
REQ-002 The block SHALL have input clk, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have input Reset, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have input step_pulse, 1 bit: one-cycle strobe; the CPU committed an instruction and the values below are valid.
REQ-005 The block SHALL have input view_sel, 2 bits: asynchronous slide switches selecting the display view.
REQ-006 The block SHALL have inputs pc_out, pc_next, reg_data1, reg_data2, alu_result and data_out, each 32 bits, taken from the CPU datapath.
REQ-007 The block SHALL have inputs rs_addr and rt_addr, each 5 bits: the CPU source register numbers.
REQ-008 The block SHALL have output an, 4 bits, active-low digit anodes; an[0] is the rightmost digit.
REQ-009 The block SHALL have output seg, 8 bits, active-low segments ordered {dp,g,f,e,d,c,b,a}.
REQ-010 The block SHALL have output snap_valid, 1 bit: high once a snapshot has been captured since reset.

Function
REQ-011 On each clk edge where step_pulse=1, the block SHALL capture every data input into the snapshot registers and set snap_valid=1.
REQ-012 The display SHALL show only snapshot values, never live inputs.
REQ-013 view_sel SHALL pass through a 2-flop synchronizer; a change on the pin SHALL take effect on the displayed value within 3 cycles.
REQ-014 Each view SHALL map to four nibbles {d3,d2,d1,d0} (d3 leftmost) as follows:
- view 0: {pc_out[7:0], pc_next[7:0]}
- view 1: {3'b0,rs_addr, reg_data1[7:0]}
- view 2: {3'b0,rt_addr, reg_data2[7:0]}
- view 3: {alu_result[7:0], data_out[7:0]}
REQ-015 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0.
REQ-016 Each time the refresh counter wraps, a 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-017 While the refresh counter equals 0, an SHALL be 4'b1111 as a ghosting blank; otherwise an SHALL drive only bit [index] low.
REQ-018 an and seg SHALL be registered: they reflect the counter, index, view and snapshot values one cycle earlier.
REQ-019 The hex decode SHALL produce these seg values (dp always 1):
- 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
- 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
REQ-020 While snap_valid=0, every digit SHALL show a dash (seg=8'hBF), whatever view_sel is.
REQ-021 If step_pulse arrives mid-digit, the new nibble SHALL appear on the next cycle without restarting the refresh counter.
REQ-022 Back-to-back step_pulse cycles SHALL each overwrite the snapshot; the last one wins.

Reset
REQ-023 While Reset=1 at a clk edge, the block SHALL clear the refresh counter, digit index, snapshot registers, synchronizer and snap_valid to 0, and set an=4'hF and seg=8'hFF.
REQ-024 Reset SHALL take priority over a simultaneous step_pulse, so no capture occurs in that cycle.
REQ-025 Asserting Reset mid-scan SHALL restart the scan at index 0 with the counter at 0.

Verification (REFRESH_DIV=4 in simulation)
REQ-026 Release Reset with no step_pulse -> snap_valid=0; an cycles 1111,1110,1110,1110,1111,1101,...; seg=BF whenever a digit is on.
REQ-027 view 0, pc_out=0x0000_0004, pc_next=0x0000_0008, one step_pulse -> snap_valid=1; digits d3..d0 = 0,4,0,8, so seg C0,99,C0,80 on an 0111,1011,1101,1110.
REQ-028 view 1, rs_addr=5'd17, reg_data1=0xAB, step -> digits 1,1,A,b; then change inputs without step_pulse -> the display is unchanged.
REQ-029 Flip view_sel 3->2 mid-digit -> the new view's nibble appears 2-3 cycles later; the anode sequence is undisturbed.
REQ-030 Assert Reset together with step_pulse while index=2 -> next cycle an=F, seg=FF, snap_valid=0; the scan restarts at index 0.

Source files
------------

// File: rtl/cpu_debug_display.sv
// Debug front panel for a single-cycle CPU. Each committed instruction can be
// captured into snapshot registers. A 4-digit multiplexed 7-segment display
// shows the low bytes of the selected datapath values, chosen by slide switches.
module cpu_debug_display #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        step_pulse,
    input  logic [1:0]  view_sel,
    input  logic [31:0] pc_out,
    input  logic [31:0] pc_next,
    input  logic [31:0] reg_data1,
    input  logic [31:0] reg_data2,
    input  logic [31:0] alu_result,
    input  logic [31:0] data_out,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        snap_valid
);
    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    // Only the low bytes are ever displayed, so only those are kept.
    logic [7:0]    snap_pc_q, snap_pcn_q, snap_rd1_q, snap_rd2_q, snap_alu_q, snap_dout_q;
    logic [4:0]    snap_rs_q, snap_rt_q;
    logic          valid_q;
    logic [1:0]    sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d, hex_seg;
    logic [15:0]   word;
    logic [3:0]    nib_arr [4];

    // Upper datapath bits are intentionally not shown on the panel.
    logic unused_bits;
    assign unused_bits = ^{pc_out[31:8], pc_next[31:8], reg_data1[31:8],
                           reg_data2[31:8], alu_result[31:8], data_out[31:8]};

    // Split the selected 16-bit view into digits; index 0 is the rightmost digit.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nib
            assign nib_arr[gi] = word[gi*4 +: 4];
        end
    endgenerate

    // Scan timing, view selection, hex decode and next anode/segment values.
    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        word    = 16'h0000;
        hex_seg = 8'hFF;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        case (sync2_q)
            2'd0:    word = {snap_pc_q, snap_pcn_q};
            2'd1:    word = {3'b000, snap_rs_q, snap_rd1_q};
            2'd2:    word = {3'b000, snap_rt_q, snap_rd2_q};
            default: word = {snap_alu_q, snap_dout_q};
        endcase
        case (nib_arr[idx_q])
            4'h0: hex_seg = 8'hC0;
            4'h1: hex_seg = 8'hF9;
            4'h2: hex_seg = 8'hA4;
            4'h3: hex_seg = 8'hB0;
            4'h4: hex_seg = 8'h99;
            4'h5: hex_seg = 8'h92;
            4'h6: hex_seg = 8'h82;
            4'h7: hex_seg = 8'hF8;
            4'h8: hex_seg = 8'h80;
            4'h9: hex_seg = 8'h90;
            4'hA: hex_seg = 8'h88;
            4'hB: hex_seg = 8'h83;
            4'hC: hex_seg = 8'hC6;
            4'hD: hex_seg = 8'hA1;
            4'hE: hex_seg = 8'h86;
            default: hex_seg = 8'h8E;
        endcase
        // Blank all anodes for the first count of each digit to avoid ghosting.
        an_d  = (cnt_q == '0) ? 4'hF : ~(4'b0001 << idx_q);
        seg_d = valid_q ? hex_seg : 8'hBF;
    end

    // State update: scan counters, switch synchronizer, snapshot capture, outputs.
    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            sync1_q     <= 2'd0;
            sync2_q     <= 2'd0;
            valid_q     <= 1'b0;
            snap_pc_q   <= 8'h00;
            snap_pcn_q  <= 8'h00;
            snap_rd1_q  <= 8'h00;
            snap_rd2_q  <= 8'h00;
            snap_alu_q  <= 8'h00;
            snap_dout_q <= 8'h00;
            snap_rs_q   <= 5'd0;
            snap_rt_q   <= 5'd0;
            an_q        <= 4'hF;
            seg_q       <= 8'hFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sync1_q <= view_sel;
            sync2_q <= sync1_q;
            an_q    <= an_d;
            seg_q   <= seg_d;
            if (step_pulse) begin
                valid_q     <= 1'b1;
                snap_pc_q   <= pc_out[7:0];
                snap_pcn_q  <= pc_next[7:0];
                snap_rd1_q  <= reg_data1[7:0];
                snap_rd2_q  <= reg_data2[7:0];
                snap_alu_q  <= alu_result[7:0];
                snap_dout_q <= data_out[7:0];
                snap_rs_q   <= rs_addr;
                snap_rt_q   <= rt_addr;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign snap_valid = valid_q;
endmodule

// File: tb/tb_cpu_debug_display.sv
// Self-checking bench for cpu_debug_display with a fast refresh divider.
module tb_cpu_debug_display;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        step_pulse = 1'b0;
    logic [1:0]  view_sel = 2'd0;
    logic [31:0] pc_out = '0, pc_next = '0, reg_data1 = '0, reg_data2 = '0;
    logic [31:0] alu_result = '0, data_out = '0;
    logic [4:0]  rs_addr = '0, rt_addr = '0;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        snap_valid;

    int checks = 0;
    int errors = 0;

    cpu_debug_display #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .Reset(Reset), .step_pulse(step_pulse), .view_sel(view_sel),
        .pc_out(pc_out), .pc_next(pc_next), .reg_data1(reg_data1), .reg_data2(reg_data2),
        .alu_result(alu_result), .data_out(data_out), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .an(an), .seg(seg), .snap_valid(snap_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time-based view: the output after each edge shows the digit determined by
    // how many cycles have elapsed since reset, using the snapshot held before it.
    logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [3:0] AN_ON [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] m_pc, m_pcn, m_rd1, m_rd2, m_alu, m_dout;
    logic [4:0] m_rs, m_rt;
    bit         m_valid;
    logic [1:0] m_pin1, m_pin2;
    int         m_n;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    bit         exp_valid;
    bit         model_ready = 0;

    always @(posedge clk) begin : model
        int         cnt, idx;
        logic [15:0] word;
        logic [3:0] nib;
        if (Reset) begin
            m_n = 0; m_valid = 0; m_pin1 = 0; m_pin2 = 0;
            {m_pc, m_pcn, m_rd1, m_rd2, m_alu, m_dout} = '0;
            m_rs = 0; m_rt = 0;
            exp_an = 4'hF; exp_seg = 8'hFF; exp_valid = 0;
            model_ready = 1;
        end else begin
            cnt = m_n % DIV;
            idx = (m_n / DIV) % 4;
            case (m_pin2)
                2'd0: word = {m_pc, m_pcn};
                2'd1: word = {3'b000, m_rs, m_rd1};
                2'd2: word = {3'b000, m_rt, m_rd2};
                default: word = {m_alu, m_dout};
            endcase
            nib = word[idx*4 +: 4];
            exp_an  = (cnt == 0) ? 4'hF : AN_ON[idx];
            exp_seg = m_valid ? HEX[nib] : 8'hBF;
            m_pin2 = m_pin1;
            m_pin1 = view_sel;
            if (step_pulse) begin
                m_valid = 1;
                m_pc = pc_out[7:0]; m_pcn = pc_next[7:0];
                m_rd1 = reg_data1[7:0]; m_rd2 = reg_data2[7:0];
                m_alu = alu_result[7:0]; m_dout = data_out[7:0];
                m_rs = rs_addr; m_rt = rt_addr;
            end
            exp_valid = m_valid;
            m_n++;
        end
    end

    // Compare every cycle, half a period after the active edge.
    always @(negedge clk) begin
        if (model_ready) begin
            chk("model_an", {28'd0, an}, {28'd0, exp_an});
            chk("model_valid", {31'd0, snap_valid}, {31'd0, exp_valid});
            if (exp_an != 4'hF || exp_seg == 8'hFF)
                chk("model_seg", {24'd0, seg}, {24'd0, exp_seg});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        step_pulse = 1'b1;
        @(negedge clk);
        step_pulse = 1'b0;
        $display("step: view=%0d pc=%h pcn=%h rs=%0d rd1=%h rt=%0d rd2=%h alu=%h dout=%h",
                 view_sel, pc_out[7:0], pc_next[7:0], rs_addr, reg_data1[7:0],
                 rt_addr, reg_data2[7:0], alu_result[7:0], data_out[7:0]);
    endtask

    task automatic wait_an(input string name, input logic [3:0] target, input logic [7:0] seg_exp);
        bit hit = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an == target) begin
                hit = 1;
                break;
            end
        end
        if (!hit) chk({name, "_timeout"}, {28'd0, an}, {28'd0, target});
        else      chk(name, {24'd0, seg}, {24'd0, seg_exp});
    endtask

    logic [3:0] an_seq [6] = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101};

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_an", {28'd0, an}, 32'hF);
        chk("reset_seg", {24'd0, seg}, 32'hFF);
        Reset = 1'b0;
        // Idle scan after reset: blanks and dashes.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("idle_an", {28'd0, an}, {28'd0, an_seq[i]});
            if (an != 4'hF) chk("idle_dash", {24'd0, seg}, 32'hBF);
        end
        chk("idle_valid", {31'd0, snap_valid}, 32'd0);

        // View 0: PC / next PC.
        pc_out = 32'h0000_0004; pc_next = 32'h0000_0008;
        step();
        chk("v0_valid", {31'd0, snap_valid}, 32'd1);
        wait_an("v0_d3", 4'b0111, 8'hC0);
        wait_an("v0_d2", 4'b1011, 8'h99);
        wait_an("v0_d1", 4'b1101, 8'hC0);
        wait_an("v0_d0", 4'b1110, 8'h80);

        // View 1: rs and reg_data1, then live inputs change without a step.
        view_sel = 2'd1; rs_addr = 5'd17; reg_data1 = 32'h0000_00AB;
        step();
        repeat (4) @(negedge clk);
        wait_an("v1_d3", 4'b0111, 8'hF9);
        wait_an("v1_d1", 4'b1101, 8'h88);
        wait_an("v1_d0", 4'b1110, 8'h83);
        rs_addr = 5'd3; reg_data1 = 32'h0000_0042;
        wait_an("v1_hold_d1", 4'b1101, 8'h88);
        wait_an("v1_hold_d0", 4'b1110, 8'h83);

        // Back-to-back steps: the second capture wins.
        view_sel = 2'd3; alu_result = 32'h0000_00FF; data_out = 32'h0000_0000;
        rt_addr = 5'd5; reg_data2 = 32'h0000_00CD;
        step_pulse = 1'b1;
        @(negedge clk);
        alu_result = 32'h0000_0012; data_out = 32'h0000_0034;
        step();
        wait_an("v3_d3", 4'b0111, 8'hF9);
        wait_an("v3_d0", 4'b1110, 8'h99);

        // Flip view 3 -> 2 mid-digit; the model checks the 2-3 cycle latency.
        wait_an("v3_d1", 4'b1101, 8'hB0);
        view_sel = 2'd2;
        wait_an("v2_d0", 4'b1110, 8'hA1);
        wait_an("v2_d2", 4'b1011, 8'h92);

        // Reset together with a step while digit 2 is lit.
        wait_an("pre_rst_d2", 4'b1011, 8'h92);
        Reset = 1'b1; step_pulse = 1'b1; pc_out = 32'h0000_0077;
        @(negedge clk);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        chk("rst_valid", {31'd0, snap_valid}, 32'd0);
        Reset = 1'b0; step_pulse = 1'b0;
        @(negedge clk);
        chk("restart_blank", {28'd0, an}, 32'hF);
        @(negedge clk);
        chk("restart_idx0", {28'd0, an}, 32'hE);
        chk("restart_dash", {24'd0, seg}, 32'hBF);
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
